uart_tx_frame: RTL



---
 rtl/uart_tx_pkg.sv | 27 ++
 rtl/uart_tx_parity.sv | 21 ++
 rtl/uart_tx_frame.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the parametrised UART transmit framer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Per-frame configuration latched alongside the data word.
  typedef struct packed {
    logic par_en;
    logic par_typ;
    logic stop2;
  } frame_cfg_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 32'd2) ? 32'd1 : 32'($clog2(w));
  endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity generator used when a word is loaded for transmission.
module uart_tx_parity
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_bit_o
);

  always_comb begin
    par_bit_o = ^data_i;
    case (par_typ_i)
      PAR_EVEN: par_bit_o = ^data_i;
      PAR_ODD:  par_bit_o = ~(^data_i);
      default:  par_bit_o = ^data_i;
    endcase
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, one or two stops,
// with a one-word holding buffer so frames can run back-to-back.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  ready,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned   CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  par_bit_q, par_bit_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  frame_cfg_t            hold_cfg_q, hold_cfg_d;
  logic                  hold_full_q, hold_full_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  eof;
  logic                  load_frame;
  frame_cfg_t            in_cfg;
  frame_cfg_t            load_cfg;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_par;

  assign accept    = Data_Valid & ~hold_full_q;
  assign eof       = ((state_q == S_STOP1) & ~stop2_q) | (state_q == S_STOP2);
  assign in_cfg    = '{par_en: PAR_EN, par_typ: PAR_TYP, stop2: STOP2};
  // A pending held word always takes priority over a fresh input word.
  assign load_data = hold_full_q ? hold_data_q : P_DATA;
  assign load_cfg  = hold_full_q ? hold_cfg_q  : in_cfg;

  uart_tx_parity #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data_i   (load_data),
    .par_typ_i(load_cfg.par_typ),
    .par_bit_o(load_par)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    stop2_d     = stop2_q;
    par_bit_d   = par_bit_q;
    hold_data_d = hold_data_q;
    hold_cfg_d  = hold_cfg_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    load_frame  = 1'b0;

    case (state_q)
      S_IDLE: load_frame = accept;
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_d = par_en_q ? S_PARITY : S_STOP1;
          tx_d    = par_en_q ? par_bit_q : 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_PARITY: begin
        state_d = S_STOP1;
        tx_d    = 1'b1;
      end
      S_STOP1: begin
        if (stop2_q) begin
          state_d = S_STOP2;
          tx_d    = 1'b1;
        end
      end
      S_STOP2: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // End of frame chains straight into the next word when one is available.
    if (eof) begin
      if (hold_full_q || accept) begin
        load_frame = 1'b1;
      end else begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    end

    if (accept && (state_q != S_IDLE) && !eof) begin
      hold_data_d = P_DATA;
      hold_cfg_d  = in_cfg;
      hold_full_d = 1'b1;
    end

    if (load_frame) begin
      state_d     = S_START;
      tx_d        = 1'b0;
      shift_d     = load_data;
      par_en_d    = load_cfg.par_en;
      stop2_d     = load_cfg.stop2;
      par_bit_d   = load_par;
      hold_full_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      stop2_q     <= 1'b0;
      par_bit_q   <= 1'b0;
      hold_data_q <= '0;
      hold_cfg_q  <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_en_q    <= par_en_d;
      stop2_q     <= stop2_d;
      par_bit_q   <= par_bit_d;
      hold_data_q <= hold_data_d;
      hold_cfg_q  <= hold_cfg_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign ready  = ~hold_full_q;
  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
